// File: rtl/bullet_controller.sv
// Player bullet pool: spawns at the muzzle on a frame tick, moves bullets up each tick,
// and retires them at the top of the screen or on a hit. Optional macro: BULLET_AUTOFIRE_EN.
`default_nettype none

module bullet_controller #(
   parameter int N_BULLETS       = 4,
   parameter int BULLET_SPEED    = 4,
   parameter int BULLET_H        = 8,
   parameter int MUZZLE_X_OFF    = 7,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    frame_tick,
   input  logic                    fire,
   input  logic [9:0]              player_x,
   input  logic [9:0]              player_y,
   input  logic [N_BULLETS-1:0]    hit,
   output logic [10*N_BULLETS-1:0] bullet_x,
   output logic [10*N_BULLETS-1:0] bullet_y,
   output logic [N_BULLETS-1:0]    bullet_active,
   output logic                    fire_ack
);

   localparam int CD_W = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES - 1);

   logic [N_BULLETS-1:0] r_active;
   logic [9:0]           r_x [N_BULLETS];
   logic [9:0]           r_y [N_BULLETS];
   logic [CD_W-1:0]      r_cooldown;
   logic                 r_fire_prev;
   logic                 r_fire_ack;

   logic                 w_fire_req;
   logic                 w_spawn;
   logic [N_BULLETS-1:0] w_free_onehot;

`ifdef BULLET_AUTOFIRE_EN
   assign w_fire_req = fire;
`else
   logic r_fire_armed;
   logic w_fire_edge;

   // A press between ticks arms one request; the next tick consumes or drops it.
   assign w_fire_edge = fire & ~r_fire_prev;
   assign w_fire_req  = r_fire_armed | w_fire_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_fire_armed <= 1'b0;
      else if (frame_tick)
         r_fire_armed <= 1'b0;
      else if (w_fire_edge)
         r_fire_armed <= 1'b1;
   end
`endif

   // Lowest-index slot that is free at the start of the cycle.
   always_comb begin
      w_free_onehot = '0;
      for (int i = N_BULLETS - 1; i >= 0; i--) begin
         if (!r_active[i]) begin
            w_free_onehot    = '0;
            w_free_onehot[i] = 1'b1;
         end
      end
   end

   assign w_spawn = frame_tick && w_fire_req && (r_cooldown == '0) &&
                    !(&r_active) && (player_y >= 10'(BULLET_H));

   // NOTE: the slot array is small and drives outputs with defined reset values,
   // so it is reset like any other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_active    <= '0;
         r_cooldown  <= '0;
         r_fire_prev <= 1'b0;
         r_fire_ack  <= 1'b0;
         for (int i = 0; i < N_BULLETS; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments keep every slot reading start-of-cycle state.
         r_fire_prev <= fire;
         r_fire_ack  <= w_spawn;

         if (w_spawn)
            r_cooldown <= CD_LOAD;
         else if (frame_tick && r_cooldown != '0)
            r_cooldown <= r_cooldown - 1'b1;

         for (int i = 0; i < N_BULLETS; i++) begin
            if (w_spawn && w_free_onehot[i]) begin
               r_active[i] <= 1'b1;
               r_x[i]      <= player_x + 10'(MUZZLE_X_OFF);
               r_y[i]      <= player_y - 10'(BULLET_H);
            end else if (r_active[i]) begin
               if (hit[i])
                  r_active[i] <= 1'b0;
               else if (frame_tick) begin
                  if (r_y[i] >= 10'(BULLET_SPEED))
                     r_y[i] <= r_y[i] - 10'(BULLET_SPEED);
                  else
                     r_active[i] <= 1'b0;
               end
            end
         end
      end
   end

   for (genvar g = 0; g < N_BULLETS; g++) begin : g_pack
      assign bullet_x[10*g +: 10] = r_x[g];
      assign bullet_y[10*g +: 10] = r_y[g];
   end

   assign bullet_active = r_active;
   assign fire_ack      = r_fire_ack;

endmodule

`default_nettype wire

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller: a behavioural model pushes the expected
// outputs of every driven cycle; they are popped and compared after the clock edge.
`timescale 1ns/1ps

module tb_bullet_controller;

   localparam int N     = 4;
   localparam int SPEED = 4;
   localparam int BH    = 8;
   localparam int MOFF  = 7;
   localparam int CD    = 8;

   typedef struct packed {
      logic [N-1:0]    active;
      logic [10*N-1:0] x;
      logic [10*N-1:0] y;
      logic            ack;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            frame_tick;
   logic            fire;
   logic [9:0]      player_x;
   logic [9:0]      player_y;
   logic [N-1:0]    hit;
   logic [10*N-1:0] bullet_x;
   logic [10*N-1:0] bullet_y;
   logic [N-1:0]    bullet_active;
   logic            fire_ack;

   int n_checks = 0;
   int n_pass   = 0;
   int ack_count;

   exp_t exp_q[$];

   // Behavioural model state
   bit m_active[N];
   int m_x[N];
   int m_y[N];
   int m_cd;
   bit m_prev;
   bit m_armed;
   bit m_ack;

   bullet_controller #(
      .N_BULLETS(N), .BULLET_SPEED(SPEED), .BULLET_H(BH),
      .MUZZLE_X_OFF(MOFF), .COOLDOWN_FRAMES(CD)
   ) dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .fire(fire),
      .player_x(player_x), .player_y(player_y), .hit(hit),
      .bullet_x(bullet_x), .bullet_y(bullet_y),
      .bullet_active(bullet_active), .fire_ack(fire_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_active[i] = 0;
         m_x[i] = 0;
         m_y[i] = 0;
      end
      m_cd = 0; m_prev = 0; m_armed = 0; m_ack = 0;
   endtask

   function automatic exp_t model_outputs();
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.active[i]    = m_active[i];
         e.x[10*i +: 10] = 10'(m_x[i]);
         e.y[10*i +: 10] = 10'(m_y[i]);
      end
      e.ack = m_ack;
      return e;
   endfunction

   // Advances the model one clock using the inputs currently driven.
   task automatic model_clock();
      bit req;
      bit edge_now;
      int slot;
      edge_now = fire && !m_prev;
`ifdef BULLET_AUTOFIRE_EN
      req = fire;
`else
      req = m_armed || edge_now;
`endif
      slot = -1;
      if (frame_tick && req && m_cd == 0 && int'(player_y) >= BH)
         for (int i = N - 1; i >= 0; i--)
            if (!m_active[i]) slot = i;
      for (int i = 0; i < N; i++) begin
         if (i == slot) begin
            m_active[i] = 1;
            m_x[i] = (int'(player_x) + MOFF) % 1024;
            m_y[i] = int'(player_y) - BH;
         end else if (m_active[i]) begin
            if (hit[i]) m_active[i] = 0;
            else if (frame_tick) begin
               if (m_y[i] >= SPEED) m_y[i] = m_y[i] - SPEED;
               else m_active[i] = 0;
            end
         end
      end
      if (slot >= 0) m_cd = CD - 1;
      else if (frame_tick && m_cd > 0) m_cd = m_cd - 1;
      if (frame_tick) m_armed = 0;
      else if (edge_now) m_armed = 1;
      m_prev = fire;
      m_ack = (slot >= 0);
   endtask

   // One clock: drive at negedge, push expectation, compare 1ns after the edge.
   task automatic step(input bit tick_v, input bit fire_v, input logic [N-1:0] hit_v);
      exp_t e;
      @(negedge clk);
      frame_tick = tick_v;
      fire       = fire_v;
      hit        = hit_v;
      model_clock();
      exp_q.push_back(model_outputs());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("active", 64'(bullet_active), 64'(e.active));
      check("bullet_x", 64'(bullet_x), 64'(e.x));
      check("bullet_y", 64'(bullet_y), 64'(e.y));
      check("fire_ack", 64'(fire_ack), 64'(e.ack));
      if (fire_ack) ack_count++;
   endtask

   task automatic idle_ticks(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 1'b0, '0);
         step(1'b1, 1'b0, '0);
      end
   endtask

   // Press fire between ticks, then tick once.
   task automatic press_and_tick();
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      step(1'b0, 1'b0, '0);
   endtask

   function automatic logic [9:0] slot_y(input int i);
      return bullet_y[10*i +: 10];
   endfunction

   function automatic logic [9:0] slot_x(input int i);
      return bullet_x[10*i +: 10];
   endfunction

   initial begin
      int saved_y;
      reset = 1'b1; frame_tick = 1'b0; fire = 1'b0; hit = '0;
      player_x = 10'd100; player_y = 10'd400;
      model_reset();
      ack_count = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_active", 64'(bullet_active), 64'd0);
      check("reset_x", 64'(bullet_x), 64'd0);
      check("reset_y", 64'(bullet_y), 64'd0);
      check("reset_ack", 64'(fire_ack), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      // First shot from (100,400)
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      check("spawn_ack", 64'(fire_ack), 64'd1);
      check("spawn_x", 64'(slot_x(0)), 64'd107);
      check("spawn_y", 64'(slot_y(0)), 64'd392);
      step(1'b0, 1'b1, '0);
      check("ack_one_cycle", 64'(fire_ack), 64'd0);
      step(1'b1, 1'b1, '0);
      check("first_move_y", 64'(slot_y(0)), 64'd388);

      // Held fire: no further spawns while held, re-press spawns again
      idle_ticks(10);
      ack_count = 0;
      for (int k = 0; k < 20; k++) begin
         step(1'b0, 1'b1, '0);
         step(1'b1, 1'b1, '0);
      end
`ifndef BULLET_AUTOFIRE_EN
      check("held_one_spawn", 64'(ack_count), 64'd1);
`endif
      press_and_tick();
`ifndef BULLET_AUTOFIRE_EN
      check("repress_spawn", 64'(ack_count), 64'd2);
`endif

      // Fill all slots, then hit slot 1 on a non-tick cycle
      idle_ticks(8);
      press_and_tick();
      check("all_active", 64'(bullet_active), 64'hF);
      step(1'b0, 1'b0, 4'b0010);
      check("hit_slot1", 64'(bullet_active), 64'hD);
      idle_ticks(8);
      press_and_tick();
      check("respawn_slot1", 64'(bullet_active), 64'hF);
      check("respawn_y", 64'(slot_y(1)), 64'd392);

      // Hit and tick together on slot 2: hit wins, y holds
      saved_y = m_y[2];
      step(1'b1, 1'b0, 4'b0100);
      check("hit_beats_move", 64'(bullet_active[2]), 64'd0);
      check("hit_y_hold", 64'(slot_y(2)), 64'(saved_y));

      // Player too high: eligible press does not spawn
      idle_ticks(8);
      player_y = 10'd5;
      ack_count = 0;
      press_and_tick();
      check("no_spawn_low_y", 64'(ack_count), 64'd0);
      check("no_spawn_active", 64'(bullet_active[2]), 64'd0);

      // Spawn at y=11 into slot 2, move to 3, then retire without wrapping
      player_y = 10'd19;
      idle_ticks(8);
      press_and_tick();
      check("low_spawn_y", 64'(slot_y(2)), 64'd11);
      step(1'b1, 1'b0, '0);
      step(1'b1, 1'b0, '0);
      check("at_y3", 64'(slot_y(2)), 64'd3);
      step(1'b1, 1'b0, '0);
      check("retire_inactive", 64'(bullet_active[2]), 64'd0);
      check("retire_y_hold", 64'(slot_y(2)), 64'd3);

      // Random traffic with occasional hits
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            player_x = 10'($urandom_range(0, 1023));
            player_y = 10'($urandom_range(0, 1023));
         end
         step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0);
      end

      // Asynchronous reset mid-cycle, then spawn on the first tick after release
      player_x = 10'd200; player_y = 10'd300;
      #2 reset = 1'b1;
      #1;
      check("async_reset_active", 64'(bullet_active), 64'd0);
      check("async_reset_y", 64'(bullet_y), 64'd0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      ack_count = 0;
      step(1'b0, 1'b1, '0);
      step(1'b1, 1'b1, '0);
      check("post_reset_spawn", 64'(ack_count), 64'd1);
      check("post_reset_x", 64'(slot_x(0)), 64'd207);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bullet_controller.md
# bullet_controller

Owns the pool of player bullets and sequences their life cycle: spawn at the player muzzle on a fire request, per-frame upward motion, and retirement at the top of the screen or on a hit. Sits between the input/player logic and the per-slot bullet sprite renderers. Registered position/active outputs feed one sprite instance per slot directly.

## Interface
- N_BULLETS, 4, number of bullet slots (1..8)
- BULLET_SPEED, 4, pixels moved up per frame tick
- BULLET_H, 8, bullet height in pixels, used for spawn position
- MUZZLE_X_OFF, 7, x offset from player_x to the bullet's left column
- COOLDOWN_FRAMES, 8, frame ticks between consecutive spawns (>=1)
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high; clears all state
- frame_tick  in  1  one-cycle pulse per video frame; all motion and spawning happen only on this cycle
- fire  in  1  fire button level, synchronous to clk
- player_x, player_y  in  10 each  player sprite top-left
- hit  in  N_BULLETS  one bit per slot; kills that slot, any cycle
- bullet_x  out  10*N_BULLETS  flattened slot x, slot i at [10i+9:10i]
- bullet_y  out  10*N_BULLETS  flattened slot y, same packing
- bullet_active  out  N_BULLETS  slot i live
- fire_ack  out  1  one-cycle pulse on the edge a bullet is spawned

## Operation
- Per slot: active bit, x[9:0], y[9:0]. Global: cooldown counter (width ceil(log2(COOLDOWN_FRAMES+1))), fire_prev register.
- Move (frame_tick high, slot active, no hit): if y >= BULLET_SPEED then y <= y - BULLET_SPEED, else active <= 0 (top-of-screen retire, no wrap). x unchanged.
- Hit: hit[i] clears active[i] on the next edge regardless of frame_tick; hit beats move. hit on an inactive slot has no effect. x/y of killed slots hold their last value.
- Fire eligibility (evaluated only on frame_tick): fire_req && cooldown == 0 && at least one slot inactive at the start of the cycle && player_y >= BULLET_H.
- Spawn: lowest-index slot inactive at the start of the cycle gets active <= 1, x <= player_x + MUZZLE_X_OFF (10-bit, mod 1024), y <= player_y - BULLET_H. A freshly spawned bullet is not moved on its spawn tick. A slot freed by hit or retire in the same cycle is not reusable until the next frame_tick.
- Cooldown: on spawn load COOLDOWN_FRAMES - 1; otherwise on frame_tick decrement if nonzero. Saturates at 0.
- Ineligible fire requests are dropped, never queued.
- fire_prev samples fire every clock.

## Timing
- Reset values: bullet_active = 0, bullet_x = 0, bullet_y = 0, fire_ack = 0, cooldown = 0, fire_prev = 0.
- All outputs registered; changes from frame_tick or hit appear one clk edge later. Outputs stable between frame ticks except for hit-driven clears.
- fire_ack asserts on the same edge the slot's active bit rises, for exactly one cycle.
- Throughput: at most one spawn per frame_tick, at most one per COOLDOWN_FRAMES ticks.
- Reset asserted mid-frame clears all slots immediately (asynchronous); first spawn possible on the first frame_tick after release.

## Configuration
- BULLET_AUTOFIRE_EN defined: fire_req = fire (level); holding fire spawns every COOLDOWN_FRAMES ticks while slots are free.
- Not defined: fire_req = fire && !fire_prev_at_last_tick, where the edge is latched between ticks (rising edge of fire since the previous frame_tick arms one request, consumed or dropped at that tick); holding fire yields one bullet only.

## Test plan
- Reset, player (100,400), one fire press before a tick -> slot 0 active at x=107, y=392, fire_ack one cycle; next tick y=388.
- Bullet at y=3, frame_tick -> slot deactivates, y stays 3, no underflow to 1023.
- Autofire on, fire held 40 ticks, N=4, COOLDOWN=8 -> spawns on ticks 0, 8, 16, 24; tick 32 spawns only if a slot has retired; slots filled 0,1,2,3 in order.
- Slots 0-3 active, hit=4'b0010 on a non-tick cycle -> active=4'b1101 next edge; fire on following tick with cooldown 0 -> spawns into slot 1.
- hit[2] and frame_tick same cycle on active slot 2 -> slot 2 inactive, y unchanged; player_y=5 with eligible fire -> no spawn, no fire_ack.
- Autofire off, fire held high across 20 ticks -> exactly one spawn; release and re-press -> second spawn once cooldown reaches 0.
